// File: rtl/sub_share_seq.sv
// Two-requester subtract sequencer: computes A - B one nibble per cycle through a
// single 4-bit adder stage, LSB nibble first, with round-robin arbitration.
module sub_share_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic             last_grant_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;

    logic [3:0]       a_nib_arr [NIB];
    logic [3:0]       b_nib_arr [NIB];
    logic [WIDTH-1:0] work_next;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum5;
    logic             last_nib;
    logic             grant1;

    // Nibble views of the captured operands, and the working result with nibble k replaced.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib_arr[gi] = a_reg[4*gi +: 4];
            assign b_nib_arr[gi] = b_reg[4*gi +: 4];
            assign work_next[4*gi +: 4] = (k_reg == KW'(gi)) ? sum5[3:0] : work_reg[4*gi +: 4];
        end
    endgenerate

    assign a_nib    = a_nib_arr[k_reg];
    assign b_nib    = b_nib_arr[k_reg];
    // Subtraction as A + ~B + carry; carry starts at 1 so the first nibble adds the two's complement.
    assign sum5     = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_reg};
    assign last_nib = (k_reg == KW'(NIB - 1));

    // Single request wins outright; on contention the requester not granted last time wins.
    assign grant1   = req1 & (~req0 | ~last_grant_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            work_reg       <= '0;
            carry_reg      <= 1'b0;
            k_reg          <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            done_id        <= 1'b0;
            diff           <= '0;
            no_borrow      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0 | req1) begin
                        owner_reg      <= grant1;
                        last_grant_reg <= grant1;
                        a_reg          <= grant1 ? a1 : a0;
                        b_reg          <= grant1 ? b1 : b0;
                        ack0           <= ~grant1;
                        ack1           <= grant1;
                        k_reg          <= '0;
                        carry_reg      <= 1'b1;
                        busy           <= 1'b1;
                        state_reg      <= CALC;
                    end
                end
                CALC: begin
                    work_reg  <= work_next;
                    carry_reg <= sum5[4];
                    if (last_nib) begin
                        diff      <= work_next;
                        no_borrow <= sum5[4];
                        done_id   <= owner_reg;
                        done      <= 1'b1;
                        k_reg     <= '0;
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
